// File: rtl/scan_pkg.sv
// Shared definitions for the scan test controller: FSM state encoding,
// default chain length and a small bit-count helper.
package scan_pkg;

  localparam int unsigned DEFAULT_CHAIN_LEN = 15;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } scan_state_e;

  function automatic logic [1:0] bit_sum(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/scan_cmp.sv
// Per-cycle scan-out comparator: counts how many of the two chain outputs
// differ from their expected bit, skipping masked positions.
module scan_cmp
  import scan_pkg::*;
(
  input  logic       so1_i,
  input  logic       so2_i,
  input  logic       exp1_i,
  input  logic       exp2_i,
  input  logic       mask1_i,
  input  logic       mask2_i,
  output logic [1:0] inc_o
);

  logic miss1;
  logic miss2;

  assign miss1 = (so1_i ^ exp1_i) & ~mask1_i;
  assign miss2 = (so2_i ^ exp2_i) & ~mask2_i;
  assign inc_o = bit_sum(miss1, miss2);

endmodule

// File: rtl/scan_test_ctrl.sv
// Two-chain scan test controller: shift in, single capture, shift out and count mismatches.
// Defining SCAN_TEST_CTRL_MASK_EN adds mask1/mask2 inputs that exclude bit positions from the compare.
module scan_test_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN,
  localparam int unsigned CNT_W = $clog2(2 * CHAIN_LEN + 1),
  localparam int unsigned IDX_W = $clog2(CHAIN_LEN)
) (
  input  logic                 refclk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pat1,
  input  logic [CHAIN_LEN-1:0] pat2,
  input  logic [CHAIN_LEN-1:0] exp1,
  input  logic [CHAIN_LEN-1:0] exp2,
`ifdef SCAN_TEST_CTRL_MASK_EN
  input  logic [CHAIN_LEN-1:0] mask1,
  input  logic [CHAIN_LEN-1:0] mask2,
`endif
  input  logic                 so1,
  input  logic                 so2,
  output logic                 test_mode,
  output logic                 se,
  output logic                 si1,
  output logic                 si2,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     mismatch_cnt
);

  localparam int unsigned MSB = CHAIN_LEN - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LEN - 1);

  scan_state_e          state_q;
  logic [IDX_W-1:0]     bit_q;
  logic [CHAIN_LEN-1:0] pat1_q;
  logic [CHAIN_LEN-1:0] pat2_q;
  logic [CHAIN_LEN-1:0] exp1_q;
  logic [CHAIN_LEN-1:0] exp2_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 test_mode_q;
  logic                 se_q;
  logic                 si1_q;
  logic                 si2_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic                 accept;
  logic                 shift_out;
  logic                 last_bit;
  logic                 mask1_bit;
  logic                 mask2_bit;
  logic [1:0]           inc;

  assign accept    = (state_q == IDLE) && start;
  assign shift_out = (state_q == SHIFT_OUT);
  assign last_bit  = (bit_q == LAST_IDX);
  assign cnt_d     = shift_out ? cnt_q + CNT_W'(inc) : cnt_q;

  // Pattern and expected registers shift left so the bit in use is always the MSB.
`ifdef SCAN_TEST_CTRL_MASK_EN
  logic [CHAIN_LEN-1:0] mask1_q;
  logic [CHAIN_LEN-1:0] mask2_q;

  always_ff @(posedge refclk or negedge reset) begin
    if (!reset) begin
      mask1_q <= '0;
      mask2_q <= '0;
    end else if (accept) begin
      mask1_q <= mask1;
      mask2_q <= mask2;
    end else if (shift_out) begin
      mask1_q <= mask1_q << 1;
      mask2_q <= mask2_q << 1;
    end
  end

  assign mask1_bit = mask1_q[MSB];
  assign mask2_bit = mask2_q[MSB];
`else
  assign mask1_bit = 1'b0;
  assign mask2_bit = 1'b0;
`endif

  scan_cmp u_cmp (
    .so1_i  (so1),
    .so2_i  (so2),
    .exp1_i (exp1_q[MSB]),
    .exp2_i (exp2_q[MSB]),
    .mask1_i(mask1_bit),
    .mask2_i(mask2_bit),
    .inc_o  (inc)
  );

  always_ff @(posedge refclk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_q       <= '0;
      pat1_q      <= '0;
      pat2_q      <= '0;
      exp1_q      <= '0;
      exp2_q      <= '0;
      cnt_q       <= '0;
      test_mode_q <= 1'b0;
      se_q        <= 1'b0;
      si1_q       <= 1'b0;
      si2_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= SHIFT_IN;
            bit_q       <= '0;
            pat1_q      <= pat1 << 1;
            pat2_q      <= pat2 << 1;
            exp1_q      <= exp1;
            exp2_q      <= exp2;
            cnt_q       <= '0;
            pass_q      <= 1'b0;
            test_mode_q <= 1'b1;
            se_q        <= 1'b1;
            si1_q       <= pat1[MSB];
            si2_q       <= pat2[MSB];
            busy_q      <= 1'b1;
          end
        end
        SHIFT_IN: begin
          if (last_bit) begin
            state_q <= CAPTURE;
            bit_q   <= '0;
            se_q    <= 1'b0;
            si1_q   <= 1'b0;
            si2_q   <= 1'b0;
          end else begin
            bit_q  <= bit_q + IDX_W'(1);
            si1_q  <= pat1_q[MSB];
            si2_q  <= pat2_q[MSB];
            pat1_q <= pat1_q << 1;
            pat2_q <= pat2_q << 1;
          end
        end
        CAPTURE: begin
          state_q <= SHIFT_OUT;
          se_q    <= 1'b1;
        end
        SHIFT_OUT: begin
          // The final compare lands on the same edge as the move to DONE, so pass uses cnt_d.
          cnt_q  <= cnt_d;
          exp1_q <= exp1_q << 1;
          exp2_q <= exp2_q << 1;
          if (last_bit) begin
            state_q <= DONE;
            bit_q   <= '0;
            se_q    <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (cnt_d == '0);
          end else begin
            bit_q <= bit_q + IDX_W'(1);
          end
        end
        DONE: begin
          state_q     <= IDLE;
          test_mode_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign test_mode    = test_mode_q;
  assign se           = se_q;
  assign si1          = si1_q;
  assign si2          = si2_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Self-checking bench for scan_test_ctrl with two behavioural 15-bit scan chains.
// Build with SCAN_TEST_CTRL_MASK_EN defined to also exercise the compare masks.
module tb_scan_test_ctrl;

  localparam int N  = 15;
  localparam int CW = $clog2(2 * N + 1);
  localparam int LATENCY = 2 * N + 2;
  localparam int MAXLAT = 70;

  logic          refclk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  pat1 = '0;
  logic [N-1:0]  pat2 = '0;
  logic [N-1:0]  exp1 = '0;
  logic [N-1:0]  exp2 = '0;
`ifdef SCAN_TEST_CTRL_MASK_EN
  logic [N-1:0]  mask1 = '0;
  logic [N-1:0]  mask2 = '0;
`endif
  logic          so1;
  logic          so2;
  logic          test_mode;
  logic          se;
  logic          si1;
  logic          si2;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] mismatch_cnt;

  // Scanned-design model: shift when se, otherwise capture (chain ^ capXor) & ~capClr.
  logic [N-1:0]  chain1 = '0;
  logic [N-1:0]  chain2 = '0;
  logic [N-1:0]  capXor1 = '0;
  logic [N-1:0]  capXor2 = '0;
  logic [N-1:0]  capClr1 = '0;
  logic [N-1:0]  capClr2 = '0;

  int checks = 0;
  int errors = 0;

  logic          seLog   [0:79];
  logic          si1Log  [0:79];
  logic          si2Log  [0:79];
  logic          busyLog [0:79];
  logic          tmLog   [0:79];
  logic          passLog [0:79];
  logic [CW-1:0] cntLog  [0:79];

  scan_test_ctrl #(.CHAIN_LEN(N)) dut (
    .refclk      (refclk),
    .reset       (reset),
    .start       (start),
    .pat1        (pat1),
    .pat2        (pat2),
    .exp1        (exp1),
    .exp2        (exp2),
`ifdef SCAN_TEST_CTRL_MASK_EN
    .mask1       (mask1),
    .mask2       (mask2),
`endif
    .so1         (so1),
    .so2         (so2),
    .test_mode   (test_mode),
    .se          (se),
    .si1         (si1),
    .si2         (si2),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .mismatch_cnt(mismatch_cnt)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) begin
    if (se) begin
      chain1 <= {chain1[N-2:0], si1};
      chain2 <= {chain2[N-2:0], si2};
    end else begin
      chain1 <= (chain1 ^ capXor1) & ~capClr1;
      chain2 <= (chain2 ^ capXor2) & ~capClr2;
    end
  end

  assign so1 = chain1[N-1];
  assign so2 = chain2[N-1];

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [N-1:0] captureOf(input logic [N-1:0] p, input logic [N-1:0] x,
                                              input logic [N-1:0] c);
    return (p ^ x) & ~c;
  endfunction

  function automatic int popcount(input logic [N-1:0] v);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(v[i]);
    return s;
  endfunction

  // Reference: number of unmasked positions where the captured word differs from expected.
  function automatic int expectedMiss(input logic [N-1:0] p1, input logic [N-1:0] p2,
                                      input logic [N-1:0] e1, input logic [N-1:0] e2);
    logic [N-1:0] m1;
    logic [N-1:0] m2;
`ifdef SCAN_TEST_CTRL_MASK_EN
    m1 = mask1;
    m2 = mask2;
`else
    m1 = '0;
    m2 = '0;
`endif
    return popcount((captureOf(p1, capXor1, capClr1) ^ e1) & ~m1) +
           popcount((captureOf(p2, capXor2, capClr2) ^ e2) & ~m2);
  endfunction

  task automatic logNow(input int idx);
    seLog[idx]   = se;
    si1Log[idx]  = si1;
    si2Log[idx]  = si2;
    busyLog[idx] = busy;
    tmLog[idx]   = test_mode;
    passLog[idx] = pass;
    cntLog[idx]  = mismatch_cnt;
  endtask

  // Launch one pattern and follow it to its done pulse; lat counts negedges after the start edge.
  task automatic runPattern(input logic [N-1:0] p1, input logic [N-1:0] p2,
                            input logic [N-1:0] e1, input logic [N-1:0] e2,
                            output int lat, output logic [CW-1:0] cntOut, output logic passOut);
    @(negedge refclk);
    pat1  = p1;
    pat2  = p2;
    exp1  = e1;
    exp2  = e2;
    start = 1'b1;
    @(negedge refclk);
    start = 1'b0;
    lat = 1;
    logNow(lat);
    while (done !== 1'b1 && lat < MAXLAT) begin
      @(negedge refclk);
      lat++;
      logNow(lat);
    end
    cntOut  = mismatch_cnt;
    passOut = pass;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge refclk);
    checks++;
    if ({test_mode, se, si1, si2, busy, done, pass, mismatch_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_held: outputs %b want all zero",
               {test_mode, se, si1, si2, busy, done, pass, mismatch_cnt});
    end
    reset = 1'b1;
    repeat (4) @(negedge refclk);
    checks++;
    if ({test_mode, se, si1, si2, busy, done, pass, mismatch_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_idle: outputs %b want all zero",
               {test_mode, se, si1, si2, busy, done, pass, mismatch_cnt});
    end
  endtask

  task automatic test_zero_pattern();
    int lat;
    logic [CW-1:0] cnt;
    logic ps;
    logic [63:0] seSeen;
    logic [63:0] seWant;
    logic [63:0] actSeen;
    logic [63:0] actWant;
    capXor1 = '0; capXor2 = '0; capClr1 = '0; capClr2 = '0;
    runPattern('0, '0, '0, '0, lat, cnt, ps);
    checks++;
    if (lat !== LATENCY) begin
      errors++;
      $display("[TB] FAIL zero_latency: done after %0d cycles want %0d", lat, LATENCY);
    end
    seSeen = '0; seWant = '0; actSeen = '0; actWant = '0;
    for (int k = 1; k <= LATENCY && k <= lat; k++) begin
      seSeen[k]  = seLog[k];
      seWant[k]  = (k <= N) || (k >= N + 2 && k <= 2 * N + 1);
      actSeen[k] = busyLog[k] & tmLog[k];
      actWant[k] = 1'b1;
    end
    checks++;
    if (seSeen !== seWant) begin
      errors++;
      $display("[TB] FAIL zero_se_wave: got %h want %h", seSeen, seWant);
    end
    checks++;
    if (actSeen !== actWant) begin
      errors++;
      $display("[TB] FAIL zero_busy_testmode: got %h want %h", actSeen, actWant);
    end
    checks++;
    if (cnt !== CW'(expectedMiss('0, '0, '0, '0)) || ps !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_result: cnt %0d pass %b want cnt 0 pass 1", cnt, ps);
    end
    @(negedge refclk);
    checks++;
    if ({done, busy, test_mode, pass} !== 4'b0001 || mismatch_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL zero_after_done: done/busy/tm/pass %b cnt %0d want 0001 cnt 0",
               {done, busy, test_mode, pass}, mismatch_cnt);
    end
  endtask

  task automatic test_single_fault();
    int lat;
    int want;
    logic [CW-1:0] cnt;
    logic ps;
    logic [N-1:0] p2;
    capXor1 = '0; capXor2 = '0; capClr1 = N'(1); capClr2 = '0;
    p2 = N'($urandom);
    want = expectedMiss(N'(15'h7FFF), p2, N'(15'h7FFF), p2);
    runPattern(N'(15'h7FFF), p2, N'(15'h7FFF), p2, lat, cnt, ps);
    checks++;
    if (lat !== LATENCY || cnt !== CW'(want) || ps !== (want == 0)) begin
      errors++;
      $display("[TB] FAIL single_fault: lat %0d cnt %0d pass %b want lat %0d cnt %0d pass %b",
               lat, cnt, ps, LATENCY, want, want == 0);
    end
  endtask

  task automatic test_all_mismatch();
    int lat;
    int want;
    logic [CW-1:0] cnt;
    logic ps;
    logic [N-1:0] p1;
    logic [N-1:0] p2;
    capXor1 = N'($urandom); capXor2 = N'($urandom); capClr1 = '0; capClr2 = '0;
    p1 = N'($urandom);
    p2 = N'($urandom);
    want = expectedMiss(p1, p2, ~captureOf(p1, capXor1, capClr1), ~captureOf(p2, capXor2, capClr2));
    runPattern(p1, p2, ~captureOf(p1, capXor1, capClr1), ~captureOf(p2, capXor2, capClr2),
               lat, cnt, ps);
    checks++;
    if (lat !== LATENCY || cnt !== CW'(want) || ps !== 1'b0) begin
      errors++;
      $display("[TB] FAIL all_mismatch: lat %0d cnt %0d pass %b want lat %0d cnt %0d pass 0",
               lat, cnt, ps, LATENCY, want);
    end
  endtask

  task automatic test_random();
    int lat;
    int want;
    logic [CW-1:0] cnt;
    logic ps;
    logic [N-1:0] p1, p2, e1, e2, siVec1, siVec2;
    logic tail;
    for (int it = 0; it < 6; it++) begin
      capXor1 = N'($urandom); capXor2 = N'($urandom);
      capClr1 = N'($urandom & $urandom); capClr2 = N'($urandom & $urandom);
      p1 = N'($urandom);
      p2 = N'($urandom);
      e1 = captureOf(p1, capXor1, capClr1);
      e2 = captureOf(p2, capXor2, capClr2);
      if (it != 0) begin
        e1 = e1 ^ N'($urandom & $urandom & $urandom);
        e2 = e2 ^ N'($urandom & $urandom & $urandom);
      end
      want = expectedMiss(p1, p2, e1, e2);
      runPattern(p1, p2, e1, e2, lat, cnt, ps);
      checks++;
      if (lat !== LATENCY || cnt !== CW'(want) || ps !== (want == 0)) begin
        errors++;
        $display("[TB] FAIL random_result[%0d]: lat %0d cnt %0d pass %b want lat %0d cnt %0d pass %b",
                 it, lat, cnt, ps, LATENCY, want, want == 0);
      end
      checks++;
      if (cntLog[1] !== '0 || passLog[1] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL random_clear[%0d]: first busy cycle cnt %0d pass %b want 0 0",
                 it, cntLog[1], passLog[1]);
      end
      siVec1 = '0; siVec2 = '0; tail = 1'b0;
      for (int k = 0; k < N; k++) begin
        siVec1[N-1-k] = si1Log[k+1];
        siVec2[N-1-k] = si2Log[k+1];
      end
      for (int k = N + 1; k <= LATENCY && k <= lat; k++) tail = tail | si1Log[k] | si2Log[k];
      checks++;
      if (siVec1 !== p1 || siVec2 !== p2 || tail !== 1'b0) begin
        errors++;
        $display("[TB] FAIL random_si[%0d]: si1 %h si2 %h tail %b want %h %h 0",
                 it, siVec1, siVec2, tail, p1, p2);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int want;
    int sawDone;
    logic [CW-1:0] cnt;
    logic ps;
    logic [N-1:0] p1, p2;
    capXor1 = N'($urandom); capXor2 = N'($urandom); capClr1 = '0; capClr2 = '0;
    p1 = N'($urandom);
    p2 = N'($urandom);
    @(negedge refclk);
    pat1 = p1; pat2 = p2; exp1 = ~p1; exp2 = ~p2;
    start = 1'b1;
    @(negedge refclk);
    start = 1'b0;
    // SHIFT_OUT cycle k is the (N+2+k)-th cycle after the start edge.
    for (int k = 1; k < N + 2 + 5; k++) @(negedge refclk);
    reset = 1'b0;
    #1;
    checks++;
    if ({test_mode, se, si1, si2, busy, done, pass, mismatch_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: outputs %b want all zero",
               {test_mode, se, si1, si2, busy, done, pass, mismatch_cnt});
    end
    repeat (2) @(negedge refclk);
    reset = 1'b1;
    sawDone = 0;
    for (int k = 0; k < 2 * N + 6; k++) begin
      @(negedge refclk);
      if (done === 1'b1 || busy === 1'b1) sawDone++;
    end
    checks++;
    if (sawDone !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_no_done: %0d active cycles after reset want 0", sawDone);
    end
    want = expectedMiss(p1, p2, captureOf(p1, capXor1, capClr1), ~captureOf(p2, capXor2, capClr2));
    runPattern(p1, p2, captureOf(p1, capXor1, capClr1), ~captureOf(p2, capXor2, capClr2),
               lat, cnt, ps);
    checks++;
    if (lat !== LATENCY || cnt !== CW'(want) || ps !== (want == 0)) begin
      errors++;
      $display("[TB] FAIL reset_mid_restart: lat %0d cnt %0d pass %b want lat %0d cnt %0d",
               lat, cnt, ps, LATENCY, want);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int wantA;
    int wantB;
    logic [N-1:0] a1, a2, ae1, ae2, b1, b2, be1, be2;
    capXor1 = N'($urandom); capXor2 = N'($urandom); capClr1 = '0; capClr2 = '0;
    a1 = N'($urandom); a2 = N'($urandom);
    b1 = N'($urandom); b2 = N'($urandom);
    ae1 = captureOf(a1, capXor1, capClr1) ^ N'($urandom & $urandom);
    ae2 = captureOf(a2, capXor2, capClr2) ^ N'($urandom & $urandom);
    be1 = captureOf(b1, capXor1, capClr1) ^ N'($urandom & $urandom & $urandom);
    be2 = captureOf(b2, capXor2, capClr2);
    wantA = expectedMiss(a1, a2, ae1, ae2);
    wantB = expectedMiss(b1, b2, be1, be2);
    @(negedge refclk);
    pat1 = a1; pat2 = a2; exp1 = ae1; exp2 = ae2;
    start = 1'b1;
    @(negedge refclk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < MAXLAT) begin
      @(negedge refclk);
      lat++;
      if (lat == 6) begin
        pat1 = b1; pat2 = b2; exp1 = be1; exp2 = be2;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    checks++;
    if (lat !== LATENCY || mismatch_cnt !== CW'(wantA) || pass !== (wantA == 0)) begin
      errors++;
      $display("[TB] FAIL ignore_busy_start: lat %0d cnt %0d pass %b want lat %0d cnt %0d",
               lat, mismatch_cnt, pass, LATENCY, wantA);
    end
    start = 1'b1;
    @(negedge refclk);
    checks++;
    if (busy !== 1'b0 || test_mode !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_done_start: busy %b tm %b want 0 0", busy, test_mode);
    end
    @(negedge refclk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || mismatch_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL accept_after_done: busy %b cnt %0d want 1 0", busy, mismatch_cnt);
    end
    lat = 1;
    while (done !== 1'b1 && lat < MAXLAT) begin
      @(negedge refclk);
      lat++;
    end
    checks++;
    if (lat !== LATENCY || mismatch_cnt !== CW'(wantB) || pass !== (wantB == 0)) begin
      errors++;
      $display("[TB] FAIL accept_after_done_result: lat %0d cnt %0d pass %b want lat %0d cnt %0d",
               lat, mismatch_cnt, pass, LATENCY, wantB);
    end
  endtask

`ifdef SCAN_TEST_CTRL_MASK_EN
  task automatic test_mask();
    int lat;
    int want;
    logic [CW-1:0] cnt;
    logic ps;
    logic [N-1:0] p1, p2, e1, e2;
    capXor1 = '0; capXor2 = '0; capClr1 = N'(1); capClr2 = '0;
    p2 = N'($urandom);
    mask1 = N'(15'h0001);
    mask2 = '0;
    want = expectedMiss(N'(15'h7FFF), p2, N'(15'h7FFF), p2);
    runPattern(N'(15'h7FFF), p2, N'(15'h7FFF), p2, lat, cnt, ps);
    checks++;
    if (lat !== LATENCY || cnt !== CW'(want) || ps !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mask_fault: lat %0d cnt %0d pass %b want lat %0d cnt %0d pass 1",
               lat, cnt, ps, LATENCY, want);
    end
    capXor1 = N'($urandom); capXor2 = N'($urandom); capClr1 = '0;
    p1 = N'($urandom); p2 = N'($urandom);
    e1 = ~captureOf(p1, capXor1, capClr1);
    e2 = ~captureOf(p2, capXor2, capClr2);
    mask1 = N'($urandom);
    mask2 = N'($urandom);
    want = expectedMiss(p1, p2, e1, e2);
    runPattern(p1, p2, e1, e2, lat, cnt, ps);
    checks++;
    if (lat !== LATENCY || cnt !== CW'(want) || ps !== (want == 0)) begin
      errors++;
      $display("[TB] FAIL mask_random: lat %0d cnt %0d pass %b want lat %0d cnt %0d",
               lat, cnt, ps, LATENCY, want);
    end
    mask1 = '0;
    mask2 = '0;
  endtask
`endif

  initial begin
    $display("[TB] scan_test_ctrl bench starting");
    test_reset();
    test_zero_pattern();
    test_single_fault();
    test_all_mismatch();
    test_random();
    test_reset_mid();
    test_ignore_start();
`ifdef SCAN_TEST_CTRL_MASK_EN
    test_mask();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_test_ctrl.md
SCAN_TEST_CTRL -- requirements
Module: scan_test_ctrl

Interface
REQ-001 Parameter: CHAIN_LEN, default 15, flops per scan chain (both chains equal length, >=2).
REQ-002 refclk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  pulse; launches one pattern when idle.
REQ-005 pat1, pat2  in  CHAIN_LEN each  stimulus for chain 1 / chain 2, sampled on accepted start.
REQ-006 exp1, exp2  in  CHAIN_LEN each  expected capture for chain 1 / chain 2, sampled on accepted start.
REQ-007 so1, so2  in  1 each  scan-out bits from the scanned design.
REQ-008 test_mode, se, si1, si2  out  1 each  registered drive to the scanned design.
REQ-009 busy  out  1  high from the cycle after accepted start until done.
REQ-010 done  out  1  one-cycle pulse at end of pattern.
REQ-011 pass  out  1  valid with done and held until next accepted start; 1 = zero mismatches.
REQ-012 mismatch_cnt  out  $clog2(2*CHAIN_LEN+1)  mismatching bits of the last pattern, held like pass.

Function
REQ-013 FSM states IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE; one shared bit counter 0..CHAIN_LEN-1.
REQ-014 IDLE: start=1 latches pat/exp, clears counter, mismatch_cnt and pass, and moves to SHIFT_IN; start while busy is ignored.
REQ-015 SHIFT_IN: CHAIN_LEN cycles, se=1, si1/si2 = pat1/pat2 bit [CHAIN_LEN-1-k] on cycle k (MSB first); then CAPTURE.
REQ-016 CAPTURE: exactly one cycle, se=0, si1=si2=0; then SHIFT_OUT.
REQ-017 SHIFT_OUT: CHAIN_LEN cycles, se=1, si1=si2=0; so1/so2 sampled at the rising edge ending cycle k and compared with exp1/exp2 bit [CHAIN_LEN-1-k].
REQ-018 Each unequal bit increments mismatch_cnt (0, 1 or 2 per cycle); the counter cannot overflow by construction.
REQ-019 DONE: one cycle, done=1, pass=(mismatch_cnt==0), busy=0 in the following cycle; then IDLE.
REQ-020 Latency: start at edge T -> done high in cycle T+2*CHAIN_LEN+2.
REQ-021 test_mode=1 in SHIFT_IN, CAPTURE, SHIFT_OUT and DONE; 0 in IDLE.
REQ-022 start coincident with DONE is ignored; start the cycle after DONE is accepted.

Reset
REQ-023 reset low (any time, including mid-pattern): state IDLE, counter 0, test_mode=se=si1=si2=0, busy=done=0, pass=0, mismatch_cnt=0.
REQ-024 A pattern interrupted by reset produces no done pulse; the first cycle after release is IDLE.

Configuration
REQ-025 Macro SCAN_TEST_CTRL_MASK_EN defined: extra inputs mask1, mask2 (CHAIN_LEN each) latched with start; a bit set to 1 excludes the matching position from comparison.
REQ-026 Macro absent: no mask ports; all 2*CHAIN_LEN bits are compared.

Structure
REQ-027 Shared package scan_pkg holds the FSM state enum typedef and default CHAIN_LEN constant.
REQ-028 One sub-module, scan_cmp, compares so1/so2 against expected/mask bits and returns the per-cycle increment (0..2).

Verification (CHAIN_LEN=15, so1/so2 driven by a behavioural 15-bit scan-chain model)
REQ-029 Reset held, then released, no start -> all outputs 0, state IDLE.
REQ-030 pat1=pat2=15'h0000, model captures 15'h0000 and exp=15'h0000; start -> se high 15 cycles, low 1, high 15; done at T+32; pass=1, mismatch_cnt=0.
REQ-031 pat1=15'h7FFF, exp1=15'h7FFF; model forces chain-1 bit 0 low on capture -> pass=0, mismatch_cnt=1.
REQ-032 exp1=~captured and exp2=~captured on both chains -> mismatch_cnt=30, pass=0.
REQ-033 reset asserted during SHIFT_OUT cycle 5 -> outputs return to reset values immediately, no done pulse; a new start completes normally.
REQ-034 start pulsed during busy and again on the DONE cycle -> both ignored; with SCAN_TEST_CTRL_MASK_EN, mask1=15'h0001 over the REQ-031 fault -> pass=1.
